mult_div_unit: RTL and testbench

- Parametrised multicycle multiply/divide unit feeding the HI/LO path of the multicycle datapath (MULT, DIV, MFHI, MFLO).
- Operands come from the A/B registers. The control unit starts an operation and waits on done.
- Results are held in internal HI/LO registers until the next operation completes.
- Radix-2 shift-add multiply and restoring divide, one iteration per clock, operand width set by parameter.

---
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed multiply/divide unit with held HI/LO results
// Optional MULT_DIV_UNSIGNED_EN adds is_unsigned for MULTU/DIVU.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_p;
    logic               r_neg_r;
    logic               r_dz;

    logic               w_signed;
    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_fin;
    logic [WIDTH-1:0]   w_r_fin;
    logic [2*WIDTH-1:0] w_p_fin;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_diff;

`ifdef MULT_DIV_UNSIGNED_EN
    assign w_signed = ~is_unsigned;
`else
    assign w_signed = 1'b1;
`endif

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == LP_LAST);
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);

    // r_acc holds the product while multiplying and {remainder, quotient} while dividing
    assign w_p_fin = r_neg_p ? -r_acc : r_acc;
    assign w_q_fin = r_neg_p ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r_fin = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_rsh - {1'b0, r_opb};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A zero divisor still spends one FIXUP cycle, which then skips the HI/LO write
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (!op) begin
                        w_next = S_MULT;
                    end else if (w_b_zero) begin
                        w_next = S_FIXUP;
                    end else begin
                        w_next = S_DIV;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc   <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_neg_p <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_neg_p <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= op & w_b_zero;
            r_opa   <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb   <= w_b_mag;
            r_acc   <= op ? {{WIDTH{1'b0}}, w_a_mag} : '0;
        end else begin
            case (r_state)
                S_MULT: begin
                    if (w_last) begin
                        {r_hi, r_lo} <= w_p_fin;
                    end else begin
                        if (r_opb[0]) r_acc <= r_acc + r_opa;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (!w_last) begin
                        if (!w_diff[WIDTH]) begin
                            r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_FIXUP: begin
                    if (!r_dz) begin
                        r_hi <= w_r_fin;
                        r_lo <= w_q_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == S_MULT) || (r_state == S_DIV) || (r_state == S_FIXUP);
    assign done     = (r_state == S_DONE);
    assign div_zero = (r_state == S_DONE) && r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed-vector bench for mult_div_unit (WIDTH=32 and WIDTH=8)
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start32, op32, busy32, done32, dz32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, op8, busy8, done8, dz8;
    logic [7:0]  a8, b8, hi8, lo8;
`ifdef MULT_DIV_UNSIGNED_EN
    logic        uns32, uns8;
`endif
    int checks;
    int failures;

    mult_div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(uns32),
`endif
        .a(a32), .b(b32), .hi(hi32), .lo(lo32),
        .busy(busy32), .done(done32), .div_zero(dz32)
    );

    mult_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned(uns8),
`endif
        .a(a8), .b(b8), .hi(hi8), .lo(lo8),
        .busy(busy8), .done(done8), .div_zero(dz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; returns at the negedge where done is seen (or after the bound).
    // lat is the number of the edge after which done appeared, edge 0 accepting start.
    task automatic run_op(input bit sel8, input bit op_i, input bit uns_i,
                          input logic [31:0] av, input logic [31:0] bv,
                          output int lat, output int busy_bad,
                          output logic [31:0] h, output logic [31:0] l, output logic dz);
        if (sel8) begin
            start8 = 1'b1; op8 = op_i; a8 = av[7:0]; b8 = bv[7:0];
        end else begin
            start32 = 1'b1; op32 = op_i; a32 = av; b32 = bv;
        end
`ifdef MULT_DIV_UNSIGNED_EN
        if (sel8) uns8 = uns_i; else uns32 = uns_i;
`endif
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        start32 = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (!(sel8 ? done8 : done32) && lat < 200) begin
            if (!(sel8 ? busy8 : busy32)) busy_bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        h  = sel8 ? {24'h0, hi8} : hi32;
        l  = sel8 ? {24'h0, lo8} : lo32;
        dz = sel8 ? dz8 : dz32;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (hi32 !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi32); end
        checks++; if (lo32 !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo32); end
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy32); end
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done32); end
        checks++; if (dz32 !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz32); end
        checks++; if ({hi8, lo8} !== 16'h0) begin failures++; $display("FAIL reset_hilo8 got=%h exp=0", {hi8, lo8}); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [31:0] va [6] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h0};
        logic [31:0] vb [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1, 32'd12345};
        logic [63:0] vp [6] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h1,
                                64'h3FFFFFFF_00000001, 64'hFFFFFFFF_80000000, 64'h0};
        int lat, bb;
        logic [31:0] h, l;
        logic dz;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 1'b0, 1'b0, va[i], vb[i], lat, bb, h, l, dz);
            checks++; if (lat !== 33) begin failures++; $display("FAIL mul_lat[%0d] got=%0d exp=33", i, lat); end
            checks++; if (bb !== 0) begin failures++; $display("FAIL mul_busy[%0d] low_cycles=%0d exp=0", i, bb); end
            checks++; if ({h, l} !== vp[i]) begin failures++; $display("FAIL mul_prod[%0d] got=%h exp=%h", i, {h, l}, vp[i]); end
            checks++; if (dz !== 1'b0) begin failures++; $display("FAIL mul_dz[%0d] got=%b exp=0", i, dz); end
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", done32); end
    endtask

    task automatic test_div();
        logic [31:0] va [7] = '{32'hFFFFFFF9, 32'd7, 32'd100, 32'hFFFFFF9C, 32'd3, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vb [7] = '{32'd2, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFF9, 32'd5, 32'hFFFFFFFF, 32'd1};
        logic [31:0] vq [7] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd14, 32'd14, 32'd0, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] vr [7] = '{32'hFFFFFFFF, 32'd1, 32'd2, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0};
        int lat, bb;
        logic [31:0] h, l;
        logic dz;
        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, 1'b1, 1'b0, va[i], vb[i], lat, bb, h, l, dz);
            checks++; if (lat !== 34) begin failures++; $display("FAIL div_lat[%0d] got=%0d exp=34", i, lat); end
            checks++; if (bb !== 0) begin failures++; $display("FAIL div_busy[%0d] low_cycles=%0d exp=0", i, bb); end
            checks++; if (l !== vq[i]) begin failures++; $display("FAIL div_quot[%0d] got=%h exp=%h", i, l, vq[i]); end
            checks++; if (h !== vr[i]) begin failures++; $display("FAIL div_rem[%0d] got=%h exp=%h", i, h, vr[i]); end
            checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_dz[%0d] got=%b exp=0", i, dz); end
        end
    endtask

    task automatic test_div_zero();
        int lat, bb;
        logic [31:0] h, l;
        logic dz;
        run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd2, lat, bb, h, l, dz);
        checks++; if ({h, l} !== {32'h1, 32'h2}) begin failures++; $display("FAIL dz_prior got=%h exp=%h", {h, l}, {32'h1, 32'h2}); end
        run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, lat, bb, h, l, dz);
        checks++; if (lat !== 1) begin failures++; $display("FAIL dz_lat got=%0d exp=1", lat); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", dz); end
        checks++; if (h !== 32'h1) begin failures++; $display("FAIL dz_hi_hold got=%h exp=1", h); end
        checks++; if (l !== 32'h2) begin failures++; $display("FAIL dz_lo_hold got=%h exp=2", l); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (dz32 !== 1'b0) begin failures++; $display("FAIL dz_pulse got=%b exp=0", dz32); end
        checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL dz_done_pulse got=%b exp=0", done32); end
    endtask

    task automatic test_reset_mid();
        int dones;
        start32 = 1'b1; op32 = 1'b0; a32 = 32'd3; b32 = 32'd5;
`ifdef MULT_DIV_UNSIGNED_EN
        uns32 = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy32); end
        checks++; if ({hi32, lo32} !== {32'h1, 32'h2}) begin failures++; $display("FAIL mid_hold got=%h exp=%h", {hi32, lo32}, {32'h1, 32'h2}); end
        repeat (4) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({hi32, lo32} !== 64'h0) begin failures++; $display("FAIL mid_rst_hilo got=%h exp=0", {hi32, lo32}); end
        checks++; if ({busy32, done32, dz32} !== 3'b000) begin failures++; $display("FAIL mid_rst_flags got=%b exp=000", {busy32, done32, dz32}); end
        reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done32) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dones); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start32 = 1'b1; op32 = 1'b0; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 200) begin @(posedge clk); @(negedge clk); lat++; end
        checks++; if ({hi32, lo32} !== 64'd12) begin failures++; $display("FAIL b2b_first got=%h exp=%h", {hi32, lo32}, 64'd12); end
        start32 = 1'b1; op32 = 1'b0; a32 = 32'd6; b32 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        checks++; if ({busy32, done32} !== 2'b10) begin failures++; $display("FAIL b2b_no_gap got=%b exp=10", {busy32, done32}); end
        lat = 0;
        while (!done32 && lat < 200) begin @(posedge clk); @(negedge clk); lat++; end
        checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_lat got=%0d exp=33", lat); end
        checks++; if ({hi32, lo32} !== 64'd42) begin failures++; $display("FAIL b2b_second got=%h exp=%h", {hi32, lo32}, 64'd42); end
    endtask

    task automatic test_width8();
        int lat, bb;
        logic [31:0] h, l;
        logic dz;
        run_op(1'b1, 1'b0, 1'b0, 32'hFF, 32'h02, lat, bb, h, l, dz);
        checks++; if (lat !== 9) begin failures++; $display("FAIL w8_mul_lat got=%0d exp=9", lat); end
        checks++; if ({h[7:0], l[7:0]} !== 16'hFFFE) begin failures++; $display("FAIL w8_mul_s got=%h exp=fffe", {h[7:0], l[7:0]}); end
        run_op(1'b1, 1'b1, 1'b0, 32'h80, 32'hFF, lat, bb, h, l, dz);
        checks++; if (lat !== 10) begin failures++; $display("FAIL w8_div_lat got=%0d exp=10", lat); end
        checks++; if ({h[7:0], l[7:0]} !== 16'h0080) begin failures++; $display("FAIL w8_div_ovf got=%h exp=0080", {h[7:0], l[7:0]}); end
`ifdef MULT_DIV_UNSIGNED_EN
        run_op(1'b1, 1'b0, 1'b1, 32'hFF, 32'h02, lat, bb, h, l, dz);
        checks++; if (lat !== 9) begin failures++; $display("FAIL w8_mulu_lat got=%0d exp=9", lat); end
        checks++; if ({h[7:0], l[7:0]} !== 16'h01FE) begin failures++; $display("FAIL w8_mulu got=%h exp=01fe", {h[7:0], l[7:0]}); end
        run_op(1'b1, 1'b1, 1'b1, 32'hFF, 32'h10, lat, bb, h, l, dz);
        checks++; if (lat !== 10) begin failures++; $display("FAIL w8_divu_lat got=%0d exp=10", lat); end
        checks++; if ({h[7:0], l[7:0]} !== 16'h0F0F) begin failures++; $display("FAIL w8_divu got=%h exp=0f0f", {h[7:0], l[7:0]}); end
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        start32 = 1'b0; op32 = 1'b0; a32 = '0; b32 = '0;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
`ifdef MULT_DIV_UNSIGNED_EN
        uns32 = 1'b0;
        uns8 = 1'b0;
`endif
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
